// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT with registered opcode.
// Optional retired-instruction counter is enabled by defining MULTICYCLE_CTRL_PERF_CNT_EN.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  input  logic [3:0]  opcode,
  input  logic        alu_sign,
  input  logic        mem_ack,
  output logic        ir_load,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic [2:0]  alu_ctl,
  output logic        reg_write_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic        wb_sel,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [15:0] instr_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    FETCH  = 3'b001,
    DECODE = 3'b010,
    EXEC   = 3'b011,
    MEM    = 3'b100,
    WB     = 3'b101,
    HALT   = 3'b110
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_ADDI = 4'b0111,
    OP_LW   = 4'b1000,
    OP_SW   = 4'b1001,
    OP_JMP  = 4'b1010,
    OP_BAN  = 4'b1011,
    OP_HALT = 4'b1111
  } opcode_t;

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [2:0] alu_dec;
  logic       op_legal;
  logic       op_is_alu;
  logic       op_is_mem;

  // Opcode is captured while in DECODE so EXEC/MEM/WB decode from a stable copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    alu_dec  = 3'b111;
    op_legal = 1'b1;
    case (op_q)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: alu_dec = 3'b000;
      OP_SUB, OP_BAN:                alu_dec = 3'b001;
      OP_AND:                        alu_dec = 3'b010;
      OP_OR:                         alu_dec = 3'b011;
      OP_XOR:                        alu_dec = 3'b100;
      OP_SLL:                        alu_dec = 3'b101;
      OP_SRL:                        alu_dec = 3'b110;
      OP_JMP, OP_HALT:               alu_dec = 3'b111;
      default: begin
        alu_dec  = 3'b111;
        op_legal = 1'b0;
      end
    endcase
  end

  assign op_is_alu = ~op_q[3];
  assign op_is_mem = (op_q == OP_LW) || (op_q == OP_SW);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      IDLE:   if (run_en) state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: begin
        op_d    = opcode;
        state_d = (opcode == OP_HALT) ? HALT : EXEC;
      end
      EXEC:   state_d = op_is_mem ? MEM : WB;
      MEM:    if (mem_ack) state_d = WB;
      WB:     state_d = run_en ? FETCH : IDLE;
      HALT:   state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ir_load      = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = 2'b00;
    alu_ctl      = 3'b111;
    reg_write_en = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    wb_sel       = 1'b0;
    halted       = 1'b0;
    illegal      = 1'b0;
    case (state_q)
      FETCH: ir_load = 1'b1;
      EXEC:  alu_ctl = alu_dec;
      MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_q == OP_SW);
      end
      WB: begin
        alu_ctl      = alu_dec;
        pc_en        = 1'b1;
        illegal      = ~op_legal;
        reg_write_en = op_is_alu || (op_q == OP_LW);
        wb_sel       = (op_q == OP_LW);
        if (op_q == OP_JMP)
          pc_sel = 2'b01;
        else if ((op_q == OP_BAN) && alu_sign)
          pc_sel = 2'b10;
      end
      HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == WB) && (cnt_q != '1))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign instr_cnt = cnt_q;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; checks the counter when
// MULTICYCLE_CTRL_PERF_CNT_EN is defined, otherwise expects instr_cnt = 0.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_en;
  logic [3:0]  opcode;
  logic        alu_sign;
  logic        mem_ack;
  logic        ir_load;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic [2:0]  alu_ctl;
  logic        reg_write_en;
  logic        mem_req;
  logic        mem_we;
  logic        wb_sel;
  logic        halted;
  logic        illegal;
  logic [2:0]  state;
  logic [15:0] instr_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned n_wb  = 0;

  multicycle_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_en       (run_en),
    .opcode       (opcode),
    .alu_sign     (alu_sign),
    .mem_ack      (mem_ack),
    .ir_load      (ir_load),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .alu_ctl      (alu_ctl),
    .reg_write_en (reg_write_en),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .wb_sel       (wb_sel),
    .halted       (halted),
    .illegal      (illegal),
    .state        (state),
    .instr_cnt    (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt();
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    check_eq("instr_cnt", instr_cnt, n_wb[15:0]);
`else
    check_eq("instr_cnt", instr_cnt, 16'd0);
`endif
  endtask

  task automatic check_idle_outs(input string tag);
    check_eq({tag, ".state"},   {13'd0, state}, 16'd0);
    check_eq({tag, ".alu_ctl"}, {13'd0, alu_ctl}, 16'd7);
    check_eq({tag, ".ctl"}, {6'd0, ir_load, pc_en, pc_sel, reg_write_en, mem_req, mem_we,
                             wb_sel, halted, illegal}, 16'd0);
  endtask

  // Entered with FETCH just sampled; leaves with the post-WB state sampled.
  task automatic do_instr(input string tag, input logic [3:0] op, input logic sign,
                          input int nmem, input logic [2:0] e_alu, input logic [1:0] e_sel,
                          input logic e_rwe, input logic e_wbs, input logic e_we,
                          input logic e_ill, input logic drop);
    opcode   = op;
    alu_sign = sign;
    mem_ack  = (nmem == 0);  // ack noise must be ignored by non-memory instructions
    check_eq({tag, ".f.state"}, {13'd0, state}, 16'd1);
    check_eq({tag, ".f.ir_load"}, {15'd0, ir_load}, 16'd1);
    step();
    check_eq({tag, ".d.state"}, {13'd0, state}, 16'd2);
    check_eq({tag, ".d.ir_load"}, {15'd0, ir_load}, 16'd0);
    check_eq({tag, ".d.alu_ctl"}, {13'd0, alu_ctl}, 16'd7);
    if (drop) run_en = 1'b0;
    step();
    check_eq({tag, ".e.state"}, {13'd0, state}, 16'd3);
    check_eq({tag, ".e.alu_ctl"}, {13'd0, alu_ctl}, {13'd0, e_alu});
    check_eq({tag, ".e.rwe"}, {15'd0, reg_write_en}, 16'd0);
    check_eq({tag, ".e.mem_req"}, {15'd0, mem_req}, 16'd0);
    for (int i = 1; i <= nmem; i++) begin
      step();
      check_eq({tag, ".m.state"}, {13'd0, state}, 16'd4);
      check_eq({tag, ".m.mem_req"}, {15'd0, mem_req}, 16'd1);
      check_eq({tag, ".m.mem_we"}, {15'd0, mem_we}, {15'd0, e_we});
      check_eq({tag, ".m.alu_ctl"}, {13'd0, alu_ctl}, 16'd7);
      mem_ack = (i == nmem);
    end
    step();
    mem_ack = 1'b0;
    check_eq({tag, ".w.state"}, {13'd0, state}, 16'd5);
    check_eq({tag, ".w.pc_en"}, {15'd0, pc_en}, 16'd1);
    check_eq({tag, ".w.pc_sel"}, {14'd0, pc_sel}, {14'd0, e_sel});
    check_eq({tag, ".w.alu_ctl"}, {13'd0, alu_ctl}, {13'd0, e_alu});
    check_eq({tag, ".w.rwe"}, {15'd0, reg_write_en}, {15'd0, e_rwe});
    check_eq({tag, ".w.wb_sel"}, {15'd0, wb_sel}, {15'd0, e_wbs});
    check_eq({tag, ".w.illegal"}, {15'd0, illegal}, {15'd0, e_ill});
    check_eq({tag, ".w.mem_req"}, {15'd0, mem_req}, 16'd0);
    n_wb++;
    step();
    check_eq({tag, ".n.state"}, {13'd0, state}, run_en ? 16'd1 : 16'd0);
    check_eq({tag, ".n.pc_en"}, {15'd0, pc_en}, 16'd0);
    check_eq({tag, ".n.illegal"}, {15'd0, illegal}, 16'd0);
    check_cnt();
  endtask

  initial begin
    rst_n    = 1'b0;
    run_en   = 1'b0;
    opcode   = 4'b0000;
    alu_sign = 1'b0;
    mem_ack  = 1'b0;
    #12;
    check_idle_outs("rst");
    check_cnt();
    #14 rst_n = 1'b1;
    step();
    step();
    check_idle_outs("idle_hold");

    run_en = 1'b1;
    step();
    //        tag    op       sg  nm alu    sel    rwe wbs we  ill drop
    do_instr("add",  4'b0000, 0, 0, 3'd0, 2'b00, 1, 0, 0, 0, 0);
    do_instr("lw",   4'b1000, 0, 4, 3'd0, 2'b00, 1, 1, 0, 0, 0);
    do_instr("sw",   4'b1001, 1, 1, 3'd0, 2'b00, 0, 0, 1, 0, 0);
    do_instr("ban1", 4'b1011, 1, 0, 3'd1, 2'b10, 0, 0, 0, 0, 0);
    do_instr("ban0", 4'b1011, 0, 0, 3'd1, 2'b00, 0, 0, 0, 0, 0);
    do_instr("jmp",  4'b1010, 1, 0, 3'd7, 2'b01, 0, 0, 0, 0, 0);
    do_instr("ill",  4'b1100, 1, 0, 3'd7, 2'b00, 0, 0, 0, 1, 0);
    do_instr("xor",  4'b0100, 0, 0, 3'd4, 2'b00, 1, 0, 0, 0, 0);
    do_instr("and",  4'b0010, 0, 0, 3'd2, 2'b00, 1, 0, 0, 0, 0);
    do_instr("addi", 4'b0111, 0, 0, 3'd0, 2'b00, 1, 0, 0, 0, 0);
    do_instr("sll",  4'b0101, 1, 0, 3'd5, 2'b00, 1, 0, 0, 0, 1);

    repeat (3) step();
    check_idle_outs("idle_after_drop");
    run_en = 1'b1;
    step();
    do_instr("srl",  4'b0110, 0, 0, 3'd6, 2'b00, 1, 0, 0, 0, 0);

    // Reset asserted mid-MEM with no ack pending.
    opcode  = 4'b1000;
    mem_ack = 1'b0;
    check_eq("rstmem.f.state", {13'd0, state}, 16'd1);
    step();
    step();
    step();
    check_eq("rstmem.m.state", {13'd0, state}, 16'd4);
    check_eq("rstmem.m.mem_req", {15'd0, mem_req}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    n_wb = 0;
    check_idle_outs("rstmem");
    check_cnt();
    @(negedge clk);
    rst_n  = 1'b1;
    run_en = 1'b0;
    step();
    check_eq("rstmem.hold", {13'd0, state}, 16'd0);
    run_en = 1'b1;
    step();
    do_instr("add2", 4'b0000, 0, 0, 3'd0, 2'b00, 1, 0, 0, 0, 0);
    do_instr("sub",  4'b0001, 0, 0, 3'd1, 2'b00, 1, 0, 0, 0, 0);
    do_instr("or",   4'b0011, 0, 0, 3'd3, 2'b00, 1, 0, 0, 0, 0);

    opcode  = 4'b1111;
    mem_ack = 1'b1;
    check_eq("halt.f.state", {13'd0, state}, 16'd1);
    step();
    check_eq("halt.d.state", {13'd0, state}, 16'd2);
    for (int i = 0; i < 21; i++) begin
      step();
      check_eq("halt.state", {13'd0, state}, 16'd6);
      check_eq("halt.halted", {15'd0, halted}, 16'd1);
      check_eq("halt.wr", {13'd0, pc_en, reg_write_en, mem_req}, 16'd0);
    end
    check_cnt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port run_en, input, 1, permits leaving IDLE for FETCH.
REQ-004 SHALL have port opcode, input, 4, decoded instruction opcode from the decoder.
REQ-005 SHALL have port alu_sign, input, 1, ALU result bit 15.
REQ-006 SHALL have port mem_ack, input, 1, data RAM completion strobe.
REQ-007 SHALL have outputs ir_load (1, capture instruction), pc_en (1, PC update strobe) and pc_sel (2: 00 = +1, 01 = jump imm, 10 = branch).
REQ-008 SHALL have outputs alu_ctl (3), reg_write_en (1), mem_req (1), mem_we (1) and wb_sel (1: 0 = ALU, 1 = RAM).
REQ-009 SHALL have outputs halted (1), illegal (1), state (3, current state code) and instr_cnt (16).

Function
REQ-010 Opcode map SHALL be: add 0000, sub 0001, and 0010, or 0011, xor 0100, sll 0101, srl 0110, addi 0111, lw 1000, sw 1001, jmp 1010, ban 1011, halt 1111; all other codes are illegal.
REQ-011 States and codes SHALL be: IDLE 000, FETCH 001, DECODE 010, EXEC 011, MEM 100, WB 101, HALT 110.
REQ-012 IDLE SHALL go to FETCH on a clock edge with run_en = 1, and otherwise stay in IDLE.
REQ-013 Fixed state sequence SHALL be:
  - FETCH always goes to DECODE, with ir_load = 1 for exactly that cycle.
  - DECODE goes to HALT on opcode 1111, otherwise to EXEC.
REQ-014 EXEC SHALL go to MEM for lw/sw, otherwise to WB.
REQ-015 In EXEC, alu_ctl SHALL be: add/addi/lw/sw 000, sub/ban 001, and 010, or 011, xor 100, sll 101, srl 110, else 111; alu_ctl SHALL be 111 outside EXEC and WB, and SHALL hold the EXEC value during WB.
REQ-016 In MEM, mem_req SHALL be 1, with mem_we = 1 for sw and 0 for lw; MEM SHALL stay until mem_ack is sampled 1, then go to WB.
REQ-017 mem_ack SHALL be ignored outside MEM.
REQ-018 WB SHALL last one cycle and SHALL assert pc_en = 1.
REQ-019 In WB, pc_sel SHALL be 01 for jmp, 10 for ban with alu_sign = 1, and 00 otherwise.
REQ-020 reg_write_en SHALL be 1 in WB only, for ALU ops (0000–0111) and lw; wb_sel SHALL be 1 only for lw in WB.
REQ-021 After WB, the next state SHALL be FETCH if run_en = 1, else IDLE; deasserting run_en mid-instruction SHALL complete the current instruction first.
REQ-022 An illegal opcode SHALL run DECODE→EXEC→WB with no register or RAM write, pc_sel = 00, and illegal = 1 during WB only.
REQ-023 HALT SHALL be absorbing until reset, with halted = 1, pc_en = 0 and no writes.
REQ-024 Latency SHALL be 4 cycles FETCH→WB for ALU, jmp, ban and illegal instructions, and 4 + n cycles for lw/sw, where n ≥ 1 is the number of MEM cycles.
REQ-025 All outputs SHALL be decoded from registered state and opcode only; no output SHALL depend combinationally on mem_ack.

Reset
REQ-026 rst_n = 0 SHALL immediately force state to IDLE and all outputs to 0, except alu_ctl = 111, including mid-MEM (mem_req drops without waiting for ack).
REQ-027 Leaving reset SHALL require a clock edge with run_en = 1 before FETCH.

Configuration
REQ-028 With macro MULTICYCLE_CTRL_PERF_CNT_EN defined, instr_cnt SHALL increment by 1 on each WB cycle, saturate at 16'hFFFF, and reset to 0.
REQ-029 Without MULTICYCLE_CTRL_PERF_CNT_EN, instr_cnt SHALL be constant 0 and no counter register SHALL be present.

Verification
REQ-030 add (0000), run_en = 1 from reset: state SHALL be 001, 010, 011, 101, then 001; ir_load in cycle 1, alu_ctl = 000 in cycles 3–4, reg_write_en and pc_en in cycle 4, pc_sel = 00.
REQ-031 lw (1000), mem_ack held 0 for 3 MEM cycles, then 1: mem_req = 1 and mem_we = 0 for 4 cycles, then WB with wb_sel = 1 and reg_write_en = 1; total latency 8 cycles.
REQ-032 sw (1001), ack in the first MEM cycle: mem_we = 1 for 1 cycle, WB with reg_write_en = 0 and pc_en = 1.
REQ-033 ban with alu_sign = 1: pc_sel = 10 in WB; ban with alu_sign = 0: pc_sel = 00; jmp: pc_sel = 01 and alu_ctl = 111 in EXEC.
REQ-034 Opcode 1100: illegal = 1 for 1 cycle in WB, with no writes; opcode 1111: state 110, halted = 1, stuck there for 20 cycles with run_en = 1.
REQ-035 rst_n pulled low during MEM: mem_req and state SHALL be 0 in the same cycle; with the counter enabled, 3 completed instructions SHALL give instr_cnt = 3, and reset SHALL return it to 0.
